// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode constants and instruction field positions
package cpu_pkg;

   localparam int IMM_W = 16;

   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_ANDI = 6'h0C;
   localparam logic [5:0] OP_ORI  = 6'h0D;
   localparam logic [5:0] OP_XORI = 6'h0E;
   localparam logic [5:0] OP_LW   = 6'h23;

   localparam int OPC_HI = 31;
   localparam int OPC_LO = 26;
   localparam int RS_HI  = 25;
   localparam int RS_LO  = 21;
   localparam int RT_HI  = 20;
   localparam int RT_LO  = 16;
   localparam int RD_HI  = 15;
   localparam int RD_LO  = 11;

endpackage

// File: rtl/decode_latch_ext_sel.sv
// rtl/decode_latch_ext_sel.sv - opcode to sign/zero extension select map
module ext_sel
   import cpu_pkg::*;
(
   input  logic [5:0] opcode,
   output logic       ext_src
);

   // Logical immediates are zero-extended; everything else sign-extends.
   always_comb begin
      ext_src = 1'b1;
      if (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI) begin
         ext_src = 1'b0;
      end
   end

endmodule

// File: rtl/decode_latch.sv
// rtl/decode_latch.sv - IF/ID boundary with two-entry skid buffer and field decode
module decode_latch
   import cpu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              inValid,
   output logic              inReady,
   input  logic [DATA_W-1:0] instrIn,
   input  logic [DATA_W-1:0] pcIn,
   output logic              outValid,
   input  logic              outReady,
   output logic [DATA_W-1:0] instrOut,
   output logic [DATA_W-1:0] pcOut,
   output logic [5:0]        opcode,
   output logic [4:0]        rs,
   output logic [4:0]        rt,
   output logic [4:0]        rd,
   output logic [DATA_W-1:0] immOut,
   output logic              extSrc
);

   logic              main_valid_q, main_valid_d;
   logic              skid_valid_q, skid_valid_d;
   logic              in_ready_q, in_ready_d;
   logic [DATA_W-1:0] main_instr_q, main_instr_d;
   logic [DATA_W-1:0] main_pc_q, main_pc_d;
   logic              main_ext_q, main_ext_d;
   logic [DATA_W-1:0] skid_instr_q, skid_instr_d;
   logic [DATA_W-1:0] skid_pc_q, skid_pc_d;
   logic              skid_ext_q, skid_ext_d;
   logic              in_ext;
   logic              accept;
   logic              drain;

   ext_sel u_ext_sel (
      .opcode  (instrIn[OPC_HI:OPC_LO]),
      .ext_src (in_ext)
   );

   assign accept = inValid && in_ready_q;
   assign drain  = main_valid_q && outReady;

   always_comb begin
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      main_instr_d = main_instr_q;
      main_pc_d    = main_pc_q;
      main_ext_d   = main_ext_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;
      skid_ext_d   = skid_ext_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (drain && skid_valid_q) begin
         main_instr_d = skid_instr_q;
         main_pc_d    = skid_pc_q;
         main_ext_d   = skid_ext_q;
         skid_valid_d = 1'b0;
      end else if (accept && (!main_valid_q || drain)) begin
         main_valid_d = 1'b1;
         main_instr_d = instrIn;
         main_pc_d    = pcIn;
         main_ext_d   = in_ext;
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_instr_d = instrIn;
         skid_pc_d    = pcIn;
         skid_ext_d   = in_ext;
      end else if (drain) begin
         main_valid_d = 1'b0;
      end
      // Registered copy keeps inReady free of any path from outReady.
      in_ready_d = !skid_valid_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
         main_instr_q <= '0;
         main_pc_q    <= '0;
         main_ext_q   <= 1'b0;
         skid_instr_q <= '0;
         skid_pc_q    <= '0;
         skid_ext_q   <= 1'b0;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
         main_instr_q <= main_instr_d;
         main_pc_q    <= main_pc_d;
         main_ext_q   <= main_ext_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
         skid_ext_q   <= skid_ext_d;
      end
   end

   assign inReady  = in_ready_q;
   assign outValid = main_valid_q;
   assign instrOut = main_instr_q;
   assign pcOut    = main_pc_q;
   assign extSrc   = main_ext_q;
   assign opcode   = main_instr_q[OPC_HI:OPC_LO];
   assign rs       = main_instr_q[RS_HI:RS_LO];
   assign rt       = main_instr_q[RT_HI:RT_LO];
   assign rd       = main_instr_q[RD_HI:RD_LO];
   assign immOut   = {{(DATA_W-IMM_W){1'b0}}, main_instr_q[IMM_W-1:0]};

endmodule

// File: tb/tb_decode_latch.sv
// tb/tb_decode_latch.sv - self-checking bench for decode_latch
module tb_decode_latch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        inValid = 1'b0;
   logic        outReady = 1'b0;
   logic [31:0] instrIn = '0;
   logic [31:0] pcIn = '0;
   logic        inReady, outValid, extSrc;
   logic [31:0] instrOut, pcOut, immOut;
   logic [5:0]  opcode;
   logic [4:0]  rs, rt, rd;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } beat_t;

   beat_t q[$];
   int    n_checks = 0;
   int    n_fail = 0;
   int    n_sent = 0;
   int    n_recv = 0;

   decode_latch #(.DATA_W(32), .IMM_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .inValid(inValid), .inReady(inReady), .instrIn(instrIn), .pcIn(pcIn),
      .outValid(outValid), .outReady(outReady), .instrOut(instrOut), .pcOut(pcOut),
      .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .immOut(immOut), .extSrc(extSrc)
   );

   always #5 clk = ~clk;

   function automatic logic exp_ext(input logic [31:0] i);
      logic [5:0] op;
      op = i[31:26];
      return !(op == 6'h0C || op == 6'h0D || op == 6'h0E);
   endfunction

   // Reference: a FIFO of capacity two; flush empties it.
   task automatic tick();
      bit acc, drn;
      acc = inValid && (q.size() < 2);
      drn = (q.size() > 0) && outReady;
      @(posedge clk);
      if (flush) begin
         q.delete();
      end else begin
         if (drn) begin
            q.delete(0);
            n_recv++;
         end
         if (acc) begin
            q.push_back('{instrIn, pcIn});
            n_sent++;
         end
      end
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p,
                        input logic r, input logic f);
      inValid = v; instrIn = i; pcIn = p; outReady = r; flush = f;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({outValid, inReady, immOut, extSrc} !== {1'b0, 1'b1, 32'h0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset: got v=%b rdy=%b imm=%h ext=%b, want v=0 rdy=1 imm=0 ext=0",
                  outValid, inReady, immOut, extSrc);
      end
      @(negedge clk);
      rst_n = 1'b1;
      q.delete();
   endtask

   task automatic test_single();
      drive(1'b1, 32'h2001FFFC, 32'h40, 1'b1, 1'b0);
      tick();
      n_checks++;
      if ({outValid, opcode, rs, rt, immOut, extSrc, pcOut} !==
          {1'b1, 6'h08, 5'd0, 5'd1, 32'h0000FFFC, 1'b1, 32'h40}) begin
         n_fail++;
         $display("FAIL single_addi: got v=%b op=%h rs=%0d rt=%0d imm=%h ext=%b pc=%h, want 1 08 0 1 0000fffc 1 00000040",
                  outValid, opcode, rs, rt, immOut, extSrc, pcOut);
      end
      drive(1'b1, 32'h34218000, 32'h44, 1'b1, 1'b0);
      tick();
      n_checks++;
      if ({outValid, opcode, immOut, extSrc} !== {1'b1, 6'h0D, 32'h00008000, 1'b0}) begin
         n_fail++;
         $display("FAIL single_ori: got v=%b op=%h imm=%h ext=%b, want 1 0d 00008000 0",
                  outValid, opcode, immOut, extSrc);
      end
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick();
      n_checks++;
      if (outValid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_drain: got outValid=%b, want 0", outValid);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] a, b, c;
      a = 32'h8C410010; b = 32'h30A5F0F0; c = 32'h1C000004;
      drive(1'b1, a, 32'h100, 1'b0, 1'b0); tick();
      drive(1'b1, b, 32'h104, 1'b0, 1'b0); tick();
      n_checks++;
      if ({outValid, inReady, instrOut} !== {1'b1, 1'b0, a}) begin
         n_fail++;
         $display("FAIL bp_full: got v=%b rdy=%b instr=%h, want 1 0 %h", outValid, inReady, instrOut, a);
      end
      drive(1'b1, c, 32'h108, 1'b0, 1'b0); tick(); tick();
      n_checks++;
      if ({outValid, inReady, instrOut, pcOut} !== {1'b1, 1'b0, a, 32'h100}) begin
         n_fail++;
         $display("FAIL bp_hold: got v=%b rdy=%b instr=%h pc=%h, want 1 0 %h 00000100",
                  outValid, inReady, instrOut, pcOut, a);
      end
      outReady = 1'b1; tick();
      n_checks++;
      if ({outValid, inReady, instrOut, pcOut, extSrc} !== {1'b1, 1'b1, b, 32'h104, 1'b0}) begin
         n_fail++;
         $display("FAIL bp_b: got v=%b rdy=%b instr=%h pc=%h ext=%b, want 1 1 %h 00000104 0",
                  outValid, inReady, instrOut, pcOut, extSrc, b);
      end
      tick();
      n_checks++;
      if ({outValid, instrOut, pcOut} !== {1'b1, c, 32'h108}) begin
         n_fail++;
         $display("FAIL bp_c: got v=%b instr=%h pc=%h, want 1 %h 00000108", outValid, instrOut, pcOut, c);
      end
      inValid = 1'b0; tick();
      n_checks++;
      if ({outValid, inReady} !== 2'b01) begin
         n_fail++;
         $display("FAIL bp_empty: got v=%b rdy=%b, want 0 1", outValid, inReady);
      end
   endtask

   task automatic test_flush();
      logic [31:0] a, d;
      a = 32'h20420001; d = 32'hDEADBEEF;
      drive(1'b1, a, 32'h200, 1'b0, 1'b0); tick();
      drive(1'b1, 32'h20420002, 32'h204, 1'b0, 1'b0); tick();
      drive(1'b1, d, 32'h208, 1'b0, 1'b1); tick();
      n_checks++;
      if ({outValid, inReady, instrOut} !== {1'b0, 1'b1, a}) begin
         n_fail++;
         $display("FAIL flush: got v=%b rdy=%b instr=%h, want 0 1 %h", outValid, inReady, instrOut, a);
      end
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      repeat (3) begin
         tick();
         n_checks++;
         if (outValid !== 1'b0 || instrOut === d) begin
            n_fail++;
            $display("FAIL flush_no_d: got v=%b instr=%h, want v=0 and no %h", outValid, instrOut, d);
         end
      end
   endtask

   task automatic test_reset_midstream();
      logic [31:0] e;
      e = 32'h39CE0005;
      drive(1'b1, 32'h11111111, 32'h300, 1'b0, 1'b0); tick();
      drive(1'b1, 32'h22222222, 32'h304, 1'b0, 1'b0); tick();
      inValid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      q.delete();
      n_checks++;
      if ({outValid, inReady, immOut} !== {1'b0, 1'b1, 32'h0}) begin
         n_fail++;
         $display("FAIL rst_mid: got v=%b rdy=%b imm=%h, want 0 1 00000000", outValid, inReady, immOut);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, e, 32'h400, 1'b1, 1'b0); tick();
      n_checks++;
      if ({outValid, instrOut, pcOut, extSrc} !== {1'b1, e, 32'h400, 1'b0}) begin
         n_fail++;
         $display("FAIL rst_e: got v=%b instr=%h pc=%h ext=%b, want 1 %h 00000400 0",
                  outValid, instrOut, pcOut, extSrc, e);
      end
      inValid = 1'b0; tick();
   endtask

   task automatic test_stream();
      logic [31:0] r;
      logic [5:0]  ops [6];
      int          cyc;
      ops[0] = 6'h0C; ops[1] = 6'h0D; ops[2] = 6'h0E;
      ops[3] = 6'h08; ops[4] = 6'h23; ops[5] = 6'h00;
      n_sent = 0; n_recv = 0; cyc = 0;
      while ((n_sent < 100 || q.size() > 0) && cyc < 2000) begin
         r = $urandom;
         if ($urandom_range(0, 1) == 0) r[31:26] = ops[$urandom_range(0, 5)];
         drive(n_sent < 100 && $urandom_range(0, 3) != 0, r, $urandom,
               (n_sent >= 100) || ($urandom_range(0, 2) != 0), 1'b0);
         tick();
         cyc++;
         n_checks++;
         if ({outValid, inReady} !== {q.size() > 0, q.size() < 2}) begin
            n_fail++;
            $display("FAIL stream_hs cyc %0d: got v=%b rdy=%b, want %b %b",
                     cyc, outValid, inReady, q.size() > 0, q.size() < 2);
         end else if (q.size() > 0) begin
            n_checks++;
            if ({instrOut, pcOut, opcode, rs, rt, rd, immOut, extSrc} !==
                {q[0].instr, q[0].pc, q[0].instr[31:26], q[0].instr[25:21], q[0].instr[20:16],
                 q[0].instr[15:11], 16'h0, q[0].instr[15:0], exp_ext(q[0].instr)}) begin
               n_fail++;
               $display("FAIL stream_data cyc %0d: got instr=%h pc=%h imm=%h ext=%b, want %h %h ext=%b",
                        cyc, instrOut, pcOut, immOut, extSrc, q[0].instr, q[0].pc, exp_ext(q[0].instr));
            end
         end
      end
      n_checks++;
      if (n_recv !== 100 || q.size() != 0) begin
         n_fail++;
         $display("FAIL stream_count: got %0d delivered with %0d pending, want 100 and 0", n_recv, q.size());
      end
      inValid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_flush();
      test_reset_midstream();
      test_stream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/decode_latch.md
# decode_latch

Registered IF→ID boundary stage of the processor datapath. Accepts fetched instruction words from the fetch unit over a valid/ready handshake. Holds them in a two-entry skid buffer and presents decoded fields downstream. Drives the sign extender's 32-bit input (low 16 bits = immediate) and its `extSrc` select, both registered.

## Interface
Parameters:
- `DATA_W`, 32: instruction / PC width.
- `IMM_W`, 16: immediate field width, taken from `instrIn[IMM_W-1:0]`.

Ports:
- `clk`: input, 1, rising-edge clock.
- `rst_n`: input, 1, asynchronous active-low reset.
- `flush`: input, 1, discards all held and incoming beats (branch/jump redirect).
- `inValid`: input, 1, fetch beat valid.
- `inReady`: output, 1, stage can accept a beat.
- `instrIn`: input, DATA_W, fetched instruction.
- `pcIn`: input, DATA_W, PC of `instrIn`.
- `outValid`: output, 1, decoded beat valid.
- `outReady`: input, 1, downstream consumes beat.
- `instrOut`: output, DATA_W, held instruction.
- `pcOut`: output, DATA_W, held PC.
- `opcode`: output, 6, `instr[31:26]`.
- `rs`: output, 5, `instr[25:21]`.
- `rt`: output, 5, `instr[20:16]`.
- `rd`: output, 5, `instr[15:11]`.
- `immOut`: output, DATA_W, `{(DATA_W-IMM_W)'b0, instr[IMM_W-1:0]}`; feeds sign extender `in`.
- `extSrc`: output, 1, 1 = signed extension, 0 = zero extension; feeds sign extender `extSrc`.

## Operation
- Two slots: main (drives all outputs) and skid. Each slot has a valid bit and stores instr, pc and extSrc.
- `inReady` = !skidValid, driven straight from a flop with no combinational path from `outReady`.
- Accept occurs when `inValid && inReady`.
- Drain occurs when `outValid && outReady`.
- Per edge, without flush:
  - main empty, or draining with skid empty: accepted beat loads main.
  - main full, not draining: accepted beat loads skid.
  - draining with skid full: skid moves to main and skid empties. No accept is possible, since `inReady` = 0.
  - draining with no accept and skid empty: main valid clears.
- `outValid` = mainValid.
- Decoded fields are slices of the main slot's instr. `extSrc` is computed at load time from the incoming opcode:
  - 0 for OP_ANDI (6'h0C), OP_ORI (6'h0D), OP_XORI (6'h0E).
  - 1 for every other opcode.
- Flush has priority over everything. Next edge: both valid bits clear, a beat accepted in the same cycle is dropped, and data registers keep their old values.
- Ordering is strictly FIFO. No beat is duplicated or lost except by flush.

## Timing
- Reset, asynchronous, active-low:
  - mainValid = skidValid = 0, so `outValid` = 0 and `inReady` = 1.
  - All data registers and `extSrc` = 0, so `immOut` = 0.
- Latency: a beat accepted at edge N appears on the outputs after edge N (one cycle).
- Throughput: one beat per cycle when `outReady` is held high.
- Output stability: outputs stay stable while `outValid && !outReady`.
- `inReady` falls the cycle after the skid loads. It rises the cycle after the skid moves to main.
- `rst_n` asserted mid-transfer discards all beats immediately. The first accept after release is a legal beat.
- Flush together with `outReady`: the current beat is counted as consumed by downstream, and the stage is still empty afterwards.

## Structure
- Shared package (`cpu_pkg`):
  - opcode constants OP_ANDI, OP_ORI, OP_XORI, OP_ADDI (6'h08), OP_LW (6'h23);
  - field bit positions;
  - IMM_W.
- One sub-module: `ext_sel`, a combinational opcode → extSrc map reused by the control unit. All state lives in `decode_latch`.

## Test plan
- Reset: hold `rst_n` = 0 → `outValid` = 0, `inReady` = 1, `immOut` = 0x00000000, `extSrc` = 0.
- Single beat, `outReady` = 1:
  - send instr 0x2001FFFC, pc 0x00000040 → one cycle later `opcode` = 0x08, `rs` = 0, `rt` = 1, `immOut` = 0x0000FFFC, `extSrc` = 1, `pcOut` = 0x40.
  - follow with 0x34218000 → `opcode` = 0x0D, `immOut` = 0x00008000, `extSrc` = 0.
- Backpressure:
  - hold `outReady` = 0 and offer beats A, B, C back-to-back → A and B accepted, `inReady` = 0 from the cycle after B, C held on the input.
  - raise `outReady` → A, B, C emerge in order on consecutive cycles.
- Flush:
  - with both slots full, assert `flush` for one cycle while offering D → next cycle `outValid` = 0, `inReady` = 1, D never appears.
- Reset mid-stream:
  - assert `rst_n` = 0 asynchronously between edges with two beats held → `outValid` drops immediately.
  - after release, beat E passes with one-cycle latency.
- Streaming:
  - 100 random beats with random `outReady` and `inValid` → scoreboard shows exact in-order delivery.
  - `extSrc` matches the opcode map for every beat.
